// File: rtl/or1200_enc_pkg.sv
// Shared constants, core state encoding and the rotate helper for the
// multi-channel encryption pad generator.
package or1200_enc_pkg;

  localparam int PAD_W  = 128;
  localparam int WORD_W = 32;
  localparam logic [PAD_W-1:0] DEFAULT_KEY = 128'h0123456789abcdef0123456789abcdef;

  typedef enum logic [1:0] {
    CORE_IDLE = 2'd0,
    CORE_RUN  = 2'd1,
    CORE_DONE = 2'd2
  } core_state_t;

  function automatic logic [PAD_W-1:0] rotl1(input logic [PAD_W-1:0] s);
    return {s[PAD_W-2:0], s[PAD_W-1]};
  endfunction

endpackage

// File: rtl/or1200_enc_pad_core.sv
// Shared keystream round engine: loads {4{seed}}^KEY on start, rotates left
// once per round for ROUNDS cycles, then presents the pad for one DONE cycle.
module or1200_enc_pad_core
  import or1200_enc_pkg::*;
#(
  parameter int                 ROUNDS = 4,
  parameter logic [PAD_W-1:0]   KEY    = DEFAULT_KEY
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WORD_W-1:0]   seed,
  output logic                busy,
  output logic                done,
  output logic [PAD_W-1:0]    pad
);

  localparam int RW = $clog2(ROUNDS + 1);

  core_state_t       state, state_next;
  logic [RW-1:0]     round_cnt;
  logic [PAD_W-1:0]  s_reg;

  always_ff @(posedge clk) begin
    if (!rst) state <= CORE_IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      round_cnt <= '0;
      s_reg     <= '0;
    end else begin
      case (state)
        CORE_IDLE: begin
          if (start) begin
            s_reg     <= {(PAD_W/WORD_W){seed}} ^ KEY;
            round_cnt <= '0;
          end
        end
        CORE_RUN: begin
          s_reg     <= rotl1(s_reg);
          round_cnt <= round_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      CORE_IDLE: if (start) state_next = CORE_RUN;
      CORE_RUN:  if (round_cnt == RW'(ROUNDS - 1)) state_next = CORE_DONE;
      CORE_DONE: state_next = CORE_IDLE;
      default:   state_next = CORE_IDLE;
    endcase
  end

  assign busy = (state != CORE_IDLE);
  assign done = (state == CORE_DONE);
  assign pad  = s_reg;

endmodule

// File: rtl/or1200_enc_pad_mc.sv
// Multi-channel pad generator: per-channel seed registers, round-robin access
// to one shared round engine, and a per-channel pad FIFO. Optional bypass via
// the OR1200_ENC_BYPASS_EN macro.
module or1200_enc_pad_mc
  import or1200_enc_pkg::*;
#(
  parameter int               NCH    = 2,
  parameter int               DEPTH  = 2,
  parameter int               ROUNDS = 4,
  parameter logic [PAD_W-1:0] KEY    = DEFAULT_KEY,
  localparam int              CW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  seed_valid,
  output logic                  seed_ready,
  input  logic [CW-1:0]         seed_ch,
  input  logic [WORD_W-1:0]     seed_data,
  input  logic [NCH-1:0]        use_i,
  input  logic [2*NCH-1:0]      word_sel,
  input  logic [NCH-1:0]        req_i,
  input  logic [NCH-1:0]        bypass,
  output logic [WORD_W*NCH-1:0] pad_word,
  output logic [NCH-1:0]        pad_avail,
  output logic [NCH-1:0]        stall
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [NCH-1:0]     pending_reg;
  logic [WORD_W-1:0]  seed_reg [NCH];
  logic [CW-1:0]      ptr_reg, owner_reg, grant_ch;
  logic               grant_valid;
  logic [NCH-1:0]     eligible, inflight, byp;
  logic               core_busy, core_done;
  logic [PAD_W-1:0]   core_pad;
  int                 idx;

`ifdef OR1200_ENC_BYPASS_EN
  assign byp = bypass;
`else
  logic unused_bypass;
  assign byp           = '0;
  assign unused_bypass = ^bypass;
`endif

  always_comb begin
    seed_ready = 1'b0;
    for (int c = 0; c < NCH; c++)
      if (seed_ch == CW'(c)) seed_ready = !pending_reg[c];
  end

  // Round-robin search starting at ptr_reg; only while the engine is idle.
  always_comb begin
    grant_valid = 1'b0;
    grant_ch    = ptr_reg;
    idx         = 0;
    if (!core_busy) begin
      for (int i = 0; i < NCH; i++) begin
        idx = (int'(ptr_reg) + i) % NCH;
        if (!grant_valid && eligible[idx]) begin
          grant_valid = 1'b1;
          grant_ch    = CW'(idx);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pending_reg <= '0;
      ptr_reg     <= '0;
      owner_reg   <= '0;
    end else begin
      if (grant_valid) begin
        pending_reg[grant_ch] <= 1'b0;
        owner_reg             <= grant_ch;
        ptr_reg               <= (grant_ch == CW'(NCH - 1)) ? '0 : grant_ch + 1'b1;
      end
      if (seed_valid && seed_ready)
        pending_reg[seed_ch] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (seed_valid && seed_ready)
      seed_reg[seed_ch] <= seed_data;
  end

  or1200_enc_pad_core #(
    .ROUNDS (ROUNDS),
    .KEY    (KEY)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .start (grant_valid),
    .seed  (seed_reg[grant_ch]),
    .busy  (core_busy),
    .done  (core_done),
    .pad   (core_pad)
  );

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [PAD_W-1:0]  mem [DEPTH];
      logic [AW-1:0]     rd_ptr_reg, wr_ptr_reg;
      logic [CNTW-1:0]   count_reg;
      logic              push, pop, avail;
      logic [PAD_W-1:0]  head;
      logic [1:0]        sel;

      assign inflight[gi] = core_busy && (owner_reg == CW'(gi));
      // In-flight pad reserves a slot so a push can never hit a full FIFO.
      assign eligible[gi] = pending_reg[gi] &&
                            ((int'(count_reg) + int'(inflight[gi])) < DEPTH);

      // A reset asserted during DONE drops the result.
      assign push  = core_done && rst && (owner_reg == CW'(gi));
      assign pop   = use_i[gi] && (count_reg != '0) && !byp[gi];
      assign avail = (count_reg != '0);
      assign head  = mem[rd_ptr_reg];
      assign sel   = word_sel[2*gi +: 2];

      always_ff @(posedge clk) begin
        if (!rst) begin
          rd_ptr_reg <= '0;
          wr_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
          if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
          case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: ;
          endcase
        end
      end

      always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= core_pad;
      end

      assign pad_avail[gi]               = avail;
      assign pad_word[WORD_W*gi +: WORD_W] = (avail && !byp[gi]) ? head[WORD_W*sel +: WORD_W] : '0;
      assign stall[gi]                   = req_i[gi] && !avail && !byp[gi];
    end
  endgenerate

endmodule

// File: tb/tb_or1200_enc_pad_mc.sv
// Scoreboard bench for or1200_enc_pad_mc (NCH=2, DEPTH=2, ROUNDS=4).
module tb_or1200_enc_pad_mc;
  import or1200_enc_pkg::*;

  localparam int NCH    = 2;
  localparam int DEPTH  = 2;
  localparam int ROUNDS = 4;
  localparam logic [127:0] KEY = 128'h0123456789abcdef0123456789abcdef;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          seed_valid = 1'b0;
  logic          seed_ready;
  logic [0:0]    seed_ch = '0;
  logic [31:0]   seed_data = '0;
  logic [1:0]    use_i = '0;
  logic [3:0]    word_sel = '0;
  logic [1:0]    req_i = '0;
  logic [1:0]    bypass = '0;
  logic [63:0]   pad_word;
  logic [1:0]    pad_avail;
  logic [1:0]    stall;

  int n_checks = 0;
  int n_fail   = 0;
  logic [127:0] exp_q0[$];
  logic [127:0] exp_q1[$];

  or1200_enc_pad_mc #(
    .NCH(NCH), .DEPTH(DEPTH), .ROUNDS(ROUNDS), .KEY(KEY)
  ) dut (
    .clk(clk), .rst(rst), .seed_valid(seed_valid), .seed_ready(seed_ready),
    .seed_ch(seed_ch), .seed_data(seed_data), .use_i(use_i), .word_sel(word_sel),
    .req_i(req_i), .bypass(bypass), .pad_word(pad_word), .pad_avail(pad_avail),
    .stall(stall)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] model_pad(input logic [31:0] s);
    logic [127:0] x;
    x = {s, s, s, s} ^ KEY;
    return (x << ROUNDS) | (x >> (128 - ROUNDS));
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    seed_valid = 1'b0; use_i = '0; req_i = '0; bypass = '0; word_sel = '0;
    rst = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    exp_q0.delete();
    exp_q1.delete();
  endtask

  // Offers one seed, waits (bounded) for the handshake, records the model pad.
  // Returns in the cycle right after the handshake edge.
  task automatic send_seed(input int ch, input logic [31:0] d);
    int n;
    seed_valid = 1'b1; seed_ch = ch[0:0]; seed_data = d; #1;
    n = 0;
    while (!seed_ready && n < 100) begin step(); n++; end
    n_checks++;
    if (n >= 100) begin
      n_fail++;
      $display("FAIL seed_handshake ch%0d: seed_ready stuck at %b, required 1", ch, seed_ready);
    end
    step();
    seed_valid = 1'b0;
    if (ch == 0) exp_q0.push_back(model_pad(d));
    else         exp_q1.push_back(model_pad(d));
    $display("seed ch%0d data %h expected pad %h", ch, d, model_pad(d));
  endtask

  task automatic wait_avail(input int ch, output int cycles);
    cycles = 0;
    while (!pad_avail[ch] && cycles < 100) begin step(); cycles++; end
    n_checks++;
    if (!pad_avail[ch]) begin
      n_fail++;
      $display("FAIL wait_avail ch%0d: pad_avail=%b after %0d cycles, required 1", ch, pad_avail[ch], cycles);
    end
  endtask

  // Scoreboard consumer: compares all four words of the head pad, then pops it.
  task automatic pop_check(input int ch);
    logic [127:0] exp;
    logic [127:0] got;
    if ((ch == 0 && exp_q0.size() == 0) || (ch == 1 && exp_q1.size() == 0)) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard ch%0d: pop with empty expected queue, got avail %b required entry", ch, pad_avail[ch]);
      return;
    end
    exp = (ch == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
    n_checks++;
    if (pad_avail[ch] !== 1'b1) begin
      n_fail++;
      $display("FAIL pad_avail ch%0d: got %b required 1", ch, pad_avail[ch]);
    end
    for (int w = 0; w < 4; w++) begin
      word_sel[2*ch +: 2] = w[1:0]; #1;
      got[32*w +: 32] = pad_word[32*ch +: 32];
    end
    word_sel = '0;
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL pad_value ch%0d: got %h required %h", ch, got, exp);
    end
    $display("pop ch%0d pad %h", ch, got);
    use_i[ch] = 1'b1;
    step();
    use_i[ch] = 1'b0; #1;
  endtask

  task automatic test_reset();
    do_reset();
    seed_ch = 1'b0; req_i = 2'b11; #1;
    n_checks++;
    if (seed_ready !== 1'b1 || pad_avail !== 2'b00 || pad_word !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b avail=%b word=%h, required 1 00 0", seed_ready, pad_avail, pad_word);
    end
    n_checks++;
    if (stall !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_stall_11: got %b required 11", stall);
    end
    req_i = 2'b01; #1;
    n_checks++;
    if (stall !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_stall_01: got %b required 01", stall);
    end
    req_i = '0;
  endtask

  task automatic test_single();
    int lat;
    logic [127:0] got;
    do_reset();
    send_seed(0, 32'h0);
    wait_avail(0, lat);
    n_checks++;
    if (lat != ROUNDS + 2) begin
      n_fail++;
      $display("FAIL single_latency: got %0d cycles required %0d", lat, ROUNDS + 2);
    end
    n_checks++;
    if (pad_word[31:0] !== 32'h9abcdef0) begin
      n_fail++;
      $display("FAIL single_word0: got %h required 9abcdef0", pad_word[31:0]);
    end
    for (int w = 0; w < 4; w++) begin
      word_sel[1:0] = w[1:0]; #1;
      got[32*w +: 32] = pad_word[31:0];
    end
    word_sel = '0;
    n_checks++;
    if (got !== 128'h123456789abcdef0123456789abcdef0) begin
      n_fail++;
      $display("FAIL single_pad: got %h required 123456789abcdef0123456789abcdef0", got);
    end
    pop_check(0);
    n_checks++;
    if (pad_avail[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL single_empty_after_pop: got %b required 0", pad_avail[0]);
    end
  endtask

  task automatic test_two_channels();
    int l0, l1;
    do_reset();
    send_seed(0, 32'hdeadbeef);
    send_seed(1, 32'h13572468);
    wait_avail(0, l0);
    n_checks++;
    if (pad_avail[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL order_ch1_early: ch1 avail %b when ch0 arrived, required 0", pad_avail[1]);
    end
    wait_avail(1, l1);
    n_checks++;
    if (l1 != ROUNDS + 2) begin
      n_fail++;
      $display("FAIL ch1_gap: got %0d cycles after ch0 required %0d", l1, ROUNDS + 2);
    end
    pop_check(0);
    pop_check(1);
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_seed(0, 32'h00000001);
    send_seed(0, 32'h00000002);
    send_seed(0, 32'h00000003);
    repeat (20) step();
    seed_ch = 1'b0; #1;
    n_checks++;
    if (seed_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_seed_ready: got %b required 0", seed_ready);
    end
    pop_check(0);
    step();
    n_checks++;
    if (seed_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL third_granted: seed_ready %b required 1", seed_ready);
    end
    repeat (ROUNDS + 2) step();
    pop_check(0);
    pop_check(0);
    n_checks++;
    if (pad_avail[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL drained: pad_avail %b required 0", pad_avail[0]);
    end
  endtask

  task automatic test_stall();
    int n;
    do_reset();
    req_i[1] = 1'b1; #1;
    n_checks++;
    if (stall[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_empty: got %b required 1", stall[1]);
    end
    use_i[1] = 1'b1;
    step();
    use_i[1] = 1'b0;
    send_seed(1, 32'hcafef00d);
    n = 0;
    while (!pad_avail[1] && n < 100) begin
      n_checks++;
      if (stall[1] !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_waiting: got %b required 1 at cycle %0d", stall[1], n);
      end
      step(); n++;
    end
    n_checks++;
    if (stall[1] !== 1'b0 || pad_avail[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_released: stall %b avail %b required 0 1", stall[1], pad_avail[1]);
    end
    pop_check(1);
    n_checks++;
    if (pad_avail[1] !== 1'b0 || stall[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_use_ignored: avail %b stall %b required 0 1", pad_avail[1], stall[1]);
    end
    req_i = '0;
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    send_seed(0, 32'h55aa55aa);
    step(); step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    exp_q0.delete();
    seed_ch = 1'b0; #1;
    n_checks++;
    if (pad_avail !== 2'b00 || seed_ready !== 1'b1 || pad_word !== 64'h0) begin
      n_fail++;
      $display("FAIL midrun_reset: avail %b ready %b word %h required 00 1 0", pad_avail, seed_ready, pad_word);
    end
    for (int k = 0; k < ROUNDS + 4; k++) begin
      step();
      n_checks++;
      if (pad_avail !== 2'b00) begin
        n_fail++;
        $display("FAIL midrun_no_push: avail %b required 00 at cycle %0d", pad_avail, k);
      end
    end
  endtask

  task automatic test_bypass();
    int lat;
    do_reset();
    bypass[0] = 1'b1; req_i[0] = 1'b1; #1;
`ifdef OR1200_ENC_BYPASS_EN
    n_checks++;
    if (stall[0] !== 1'b0 || pad_word[31:0] !== 32'h0) begin
      n_fail++;
      $display("FAIL bypass_empty: stall %b word %h required 0 0", stall[0], pad_word[31:0]);
    end
    send_seed(0, 32'h0badf00d);
    wait_avail(0, lat);
    n_checks++;
    if (pad_word[31:0] !== 32'h0) begin
      n_fail++;
      $display("FAIL bypass_word: got %h required 0", pad_word[31:0]);
    end
    use_i[0] = 1'b1;
    step();
    use_i[0] = 1'b0;
    bypass[0] = 1'b0;
    pop_check(0);
`else
    n_checks++;
    if (stall[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL bypass_ignored: stall %b required 1", stall[0]);
    end
    send_seed(0, 32'h0badf00d);
    wait_avail(0, lat);
    use_i[0] = 1'b1;
    step();
    use_i[0] = 1'b0;
    n_checks++;
    if (pad_avail[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL bypass_pop_ignored: avail %b required 0", pad_avail[0]);
    end
    exp_q0.delete();
`endif
    bypass = '0; req_i = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_channels();
    test_back_to_back();
    test_stall();
    test_reset_mid_run();
    test_bypass();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/or1200_enc_pad_mc.md
OR1200_ENC_PAD_MC -- requirements
Module: or1200_enc_pad_mc

Interface
REQ-001 SHALL have parameter NCH, default 2, number of independent pad channels (1..8).
REQ-002 SHALL have parameter DEPTH, default 2, pad buffer entries per channel (power of 2, 1..8).
REQ-003 SHALL have parameter ROUNDS, default 4, keystream rounds per pad (1..32).
REQ-004 SHALL have parameter KEY, default 128'h0123456789abcdef0123456789abcdef, the encryption key.
REQ-005 SHALL have port clk  in  1  sole clock; one clock, all logic on its rising edge.
REQ-006 SHALL have port rst  in  1  reset; synchronous, active-low.
REQ-007 SHALL have port seed_valid  in  1  seed offered.
REQ-008 SHALL have port seed_ready  out  1  seed accepted when high with seed_valid.
REQ-009 SHALL have port seed_ch  in  clog2(NCH) (min 1)  target channel of the seed.
REQ-010 SHALL have port seed_data  in  32  seed word.
REQ-011 SHALL have port use_i  in  NCH  per-channel pad consume pulse (data cache ack).
REQ-012 SHALL have port word_sel  in  2*NCH  per-channel 32-bit word index into the 128-bit pad.
REQ-013 SHALL have port req_i  in  NCH  per-channel memory access pending.
REQ-014 SHALL have port bypass  in  NCH  per-channel plaintext request (see Configuration).
REQ-015 SHALL have port pad_word  out  32*NCH  selected word of the head pad per channel.
REQ-016 SHALL have port pad_avail  out  NCH  head pad valid per channel.
REQ-017 SHALL have port stall  out  NCH  pipeline stall per channel.

Function
REQ-018 SHALL hold one pending-seed register per channel; seed_ready = !pending[seed_ch]; handshake sets pending and captures seed_data.
REQ-019 SHALL arbitrate one shared keystream core round-robin among channels with pending set and (fifo count + in-flight) < DEPTH; pointer advances past the granted channel.
REQ-020 SHALL grant only when the core is IDLE; core states IDLE -> RUN (ROUNDS cycles) -> DONE (1 cycle, push) -> IDLE; grant clears pending in the same cycle.
REQ-021 SHALL compute s0 = {4{seed}} ^ KEY, then per round s = rotl(s,1); result after ROUNDS rounds is pushed; grant-to-pad_avail latency = ROUNDS+2 cycles.
REQ-022 SHALL keep a per-channel FIFO of DEPTH 128-bit pads; use_i[c] pops when non-empty; use_i[c] on empty is ignored.
REQ-023 SHALL, on simultaneous push and pop in one channel, leave count unchanged and order preserved; reservation guarantees push never meets a full FIFO.
REQ-024 SHALL drive pad_word[c] = head[32*word_sel[c]+:32] when pad_avail[c], else 0; word_sel 0 = bits 31:0.
REQ-025 SHALL drive stall[c] = req_i[c] & !pad_avail[c], combinationally.
REQ-026 SHALL accept a new seed for a channel in the same cycle its pending seed is granted (seed_ready reflects registered pending, so next cycle).

Reset
REQ-027 SHALL, while rst low at a clock edge, clear all pending, FIFOs, counts, in-flight flags, core to IDLE, arbiter pointer to 0.
REQ-028 SHALL after reset drive seed_ready=1, pad_avail=0, pad_word=0, stall=req_i.
REQ-029 SHALL, on reset during RUN/DONE, discard the in-flight result with no push.

Configuration
REQ-030 SHALL, with OR1200_ENC_BYPASS_EN defined, force pad_word[c]=0 and stall[c]=0 when bypass[c]=1, and ignore use_i[c] (no pop).
REQ-031 SHALL, without OR1200_ENC_BYPASS_EN, keep port bypass present but ignored.

Structure
REQ-032 SHALL place default KEY, pad width 128, word width 32 and the rotate helper function in shared package or1200_enc_pkg.
REQ-033 SHALL implement the round engine as sub-module or1200_enc_pad_core (start, seed, busy, done, pad).

Verification
REQ-034 SHALL cover: reset, seed 0 to ch0, ROUNDS=4 -> pad_avail[0] 6 cycles after grant, pad = 128'h123456789abcdef0123456789abcdef0, word_sel 0 -> 32'h9abcdef0.
REQ-035 SHALL cover: seeds to ch0 and ch1 same cycle span -> ch0 granted first, ch1 next; ch1 pad_avail ROUNDS+2 cycles after ch0.
REQ-036 SHALL cover: DEPTH=2, three seeds to ch0 without use_i -> third stays pending, seed_ready=0; one use_i -> third granted and pushed.
REQ-037 SHALL cover: req_i[1]=1 with empty ch1 -> stall[1]=1 until pad_avail[1]; use_i on empty -> no count change.
REQ-038 SHALL cover: rst low mid-RUN -> no push, pad_avail=0, seed_ready=1 next cycle.
REQ-039 SHALL cover: OR1200_ENC_BYPASS_EN, bypass[0]=1, req_i[0]=1, empty FIFO -> stall[0]=0, pad_word[0]=0.
